i2s_intr_axil_slave: RTL

AXI4-Lite responder and interrupt controller for the I2S codec IP. It latches event pulses from the codec datapath, gates them through global and per-source enables, and drives the `irq` line. Software services interrupts through a five-register map at the codec's interrupt base address. It terminates the interrupt AXI4-Lite port that the system master or the BFM drives.

---
 rtl/i2s_intr_pkg.sv | 40 ++++
 rtl/i2s_intr_capture.sv | 49 ++++
 rtl/i2s_intr_axil_slave.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_intr_pkg.sv
// Shared definitions for the I2S interrupt controller: register word
// offsets, AXI response code, FSM state types and a byte-strobe merge helper.
package i2s_intr_pkg;

    // Register word offsets, compared against ADDR[4:2]
    localparam logic [2:0] GIE_OFS = 3'd0;
    localparam logic [2:0] IER_OFS = 3'd1;
    localparam logic [2:0] ISR_OFS = 3'd2;
    localparam logic [2:0] IAR_OFS = 3'd3;
    localparam logic [2:0] IPR_OFS = 3'd4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Merge new_val into old_val one byte lane at a time, under strb
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/i2s_intr_capture.sv
// Event capture for the I2S interrupt controller: event detection, the
// latched status register (ISR) and pending gating (IPR = ISR & IER).
// Build option: define I2S_INTR_EDGE_EN for rising-edge events; the default
// build treats a high source as an event every cycle (level-sensitive).
module i2s_intr_capture #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] intr_src,
    input  logic [N-1:0] ier,
    input  logic [N-1:0] iar_clr,
    output logic [N-1:0] isr,
    output logic [N-1:0] ipr
);

    logic [N-1:0] event_s;
    logic [N-1:0] isr_r;

`ifdef I2S_INTR_EDGE_EN
    logic [N-1:0] src_d_r;

    // Keep one delayed copy of the sources to find rising edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_d_r <= {N{1'b0}};
        end else begin
            src_d_r <= intr_src;
        end
    end

    assign event_s = intr_src & ~src_d_r;
`else
    assign event_s = intr_src;
`endif

    // Latch enabled events; a simultaneous acknowledge loses to a new event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr_r <= {N{1'b0}};
        end else begin
            isr_r <= (isr_r & ~iar_clr) | (event_s & ier);
        end
    end

    assign isr = isr_r;
    assign ipr = isr_r & ier;

endmodule

// File: rtl/i2s_intr_axil_slave.sv
// AXI4-Lite register slave and interrupt controller for the I2S codec.
// Holds the write/read channel FSMs, GIE/IER registers, read-data mux and
// the registered irq output; event capture lives in i2s_intr_capture.
// Build option: I2S_INTR_EDGE_EN selects edge-triggered events (see capture).
module i2s_intr_axil_slave
    import i2s_intr_pkg::*;
#(
    parameter int C_NUM_OF_INTR      = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_IRQ_ACTIVE_STATE = 1
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [C_NUM_OF_INTR-1:0]        intr_src,
    output logic                            irq
);

    localparam int   N      = C_NUM_OF_INTR;
    localparam logic IRQ_ON = (C_IRQ_ACTIVE_STATE != 0) ? 1'b1 : 1'b0;

    wr_state_t    wr_state_r, wr_state_s;
    rd_state_t    rd_state_r, rd_state_s;
    logic         wr_hs_s, rd_hs_s;
    logic [2:0]   waddr_s, raddr_s;
    logic         gie_r;
    logic [N-1:0] ier_r;
    logic [N-1:0] isr_s, ipr_s, iar_clr_s;
    logic [31:0]  ier_ext_s, isr_ext_s, ipr_ext_s;
    logic [31:0]  gie_word_s, ier_word_s;
    logic [31:0]  rdata_s, rdata_r;
    logic         irq_r;
    logic         unused_ok_s;

    assign waddr_s = S_AXI_AWADDR[4:2];
    assign raddr_s = S_AXI_ARADDR[4:2];

    // Both address and data must be present; accept them in the same cycle
    assign wr_hs_s = (wr_state_r == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs_s = (rd_state_r == R_IDLE) && S_AXI_ARVALID;

    // Zero-extend the N-bit registers to the bus width
    always_comb begin
        ier_ext_s = 32'h0000_0000;
        isr_ext_s = 32'h0000_0000;
        ipr_ext_s = 32'h0000_0000;
        ier_ext_s[N-1:0] = ier_r;
        isr_ext_s[N-1:0] = isr_s;
        ipr_ext_s[N-1:0] = ipr_s;
    end

    assign gie_word_s = apply_wstrb({31'h0000_0000, gie_r}, S_AXI_WDATA, S_AXI_WSTRB);
    assign ier_word_s = apply_wstrb(ier_ext_s, S_AXI_WDATA, S_AXI_WSTRB);

    // Write channel state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_r <= W_IDLE;
        end else begin
            wr_state_r <= wr_state_s;
        end
    end

    // Write channel next state: accept, then hold the response until taken
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (wr_hs_s) begin
                    wr_state_s = W_RESP;
                end else begin
                    wr_state_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_s = W_IDLE;
                end else begin
                    wr_state_s = W_RESP;
                end
            end
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Commit GIE/IER writes in the handshake cycle, honouring byte strobes
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gie_r <= 1'b0;
            ier_r <= {N{1'b0}};
        end else if (wr_hs_s) begin
            case (waddr_s)
                GIE_OFS: gie_r <= gie_word_s[0];
                IER_OFS: ier_r <= ier_word_s[N-1:0];
                default: ;
            endcase
        end
    end

    // Acknowledge pulse for the capture block; strobes do not apply to IAR
    always_comb begin
        iar_clr_s = {N{1'b0}};
        if (wr_hs_s && (waddr_s == IAR_OFS)) begin
            iar_clr_s = S_AXI_WDATA[N-1:0];
        end else begin
            iar_clr_s = {N{1'b0}};
        end
    end

    i2s_intr_capture #(
        .N (N)
    ) u_capture (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .intr_src (intr_src),
        .ier      (ier_r),
        .iar_clr  (iar_clr_s),
        .isr      (isr_s),
        .ipr      (ipr_s)
    );

    // Read channel state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_r <= R_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Read channel next state: accept address, then hold data until taken
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (rd_hs_s) begin
                    rd_state_s = R_DATA;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_s = R_IDLE;
                end else begin
                    rd_state_s = R_DATA;
                end
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Read mux; IAR and the unmapped words read as zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (raddr_s)
            GIE_OFS: rdata_s[0] = gie_r;
            IER_OFS: rdata_s = ier_ext_s;
            ISR_OFS: rdata_s = isr_ext_s;
            IPR_OFS: rdata_s = ipr_ext_s;
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // Capture read data in the address handshake cycle and hold it
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_hs_s) begin
            rdata_r <= rdata_s;
        end
    end

    // Registered interrupt request with configurable active level
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_r <= ~IRQ_ON;
        end else if (gie_r && (|ipr_s)) begin
            irq_r <= IRQ_ON;
        end else begin
            irq_r <= ~IRQ_ON;
        end
    end

    assign S_AXI_AWREADY = wr_hs_s;
    assign S_AXI_WREADY  = wr_hs_s;
    assign S_AXI_BVALID  = (wr_state_r == W_RESP);
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = rd_hs_s;
    assign S_AXI_RVALID  = (rd_state_r == R_DATA);
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RDATA   = rdata_r;
    assign irq           = irq_r;

    // Protection bits, byte-offset bits and upper merge bits carry no meaning here
    assign unused_ok_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                           gie_word_s, ier_word_s};

endmodule
